// File: rtl/store_issue_ctrl.sv
// Store issue controller: computes the effective address, rejects misaligned stores and
// streams legal stores in program order onto a single-outstanding req/ack write port.
`ifndef SB
`define SB 3'b000
`endif
`ifndef SH
`define SH 3'b001
`endif
`ifndef SW
`define SW 3'b010
`endif
`ifndef STR_NOP
`define STR_NOP 3'b011
`endif

module store_issue_ctrl #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [2:0]  store_control,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic [11:0] imm,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   output logic        misalign_err,
   output logic [31:0] misalign_addr,
   output logic        busy
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned ENT_W = 30 + 4 + 32;

   typedef enum logic {IDLE, REQ} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [ENT_W-1:0]     queue_q [DEPTH];
   logic [ENT_W-1:0]     queue_d [DEPTH];
   logic                 mem_req_q, mem_req_d;
   logic [31:0]          mem_addr_q, mem_addr_d;
   logic [31:0]          mem_wdata_q, mem_wdata_d;
   logic [3:0]           mem_be_q, mem_be_d;
   logic                 misalign_err_q, misalign_err_d;
   logic [31:0]          misalign_addr_q, misalign_addr_d;

   logic [31:0]          ea;
   logic [3:0]           st_be;
   logic [31:0]          st_data;
   logic                 st_legal;
   logic                 st_misal;
   logic                 accept;
   logic                 enq;
   logic                 pop;
   logic [ENT_W-1:0]     head;

   assign st_ready = ~reset & (count_q < CNT_W'(DEPTH));
   assign accept   = st_valid & st_ready;
   assign enq      = accept & st_legal;
   assign head     = queue_q[rd_ptr_q];

   // Decode: effective address, alignment check, byte enables and lane-replicated data
   always_comb begin
      ea       = rs1_val + {{20{imm[11]}}, imm};
      st_be    = 4'b0000;
      st_data  = 32'h0;
      st_legal = 1'b0;
      st_misal = 1'b0;
      case (store_control)
         `SW: begin
            if (ea[1:0] == 2'b00) begin
               st_legal = 1'b1;
               st_be    = 4'b1111;
               st_data  = rs2_val;
            end else begin
               st_misal = 1'b1;
            end
         end
         `SH: begin
            if (!ea[0]) begin
               st_legal = 1'b1;
               st_be    = ea[1] ? 4'b1100 : 4'b0011;
               st_data  = {2{rs2_val[15:0]}};
            end else begin
               st_misal = 1'b1;
            end
         end
         `SB: begin
            st_legal = 1'b1;
            st_be    = 4'b0001 << ea[1:0];
            st_data  = {4{rs2_val[7:0]}};
         end
         default: ;
      endcase
   end

   // Issue FSM: IDLE loads the head; REQ holds the payload until ack, then chains or drains
   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop       = 1'b1;
               mem_req_d = 1'b1;
               state_d   = REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               if (count_q != '0) begin
                  pop = 1'b1;
               end else begin
                  mem_req_d = 1'b0;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (pop) begin
         mem_addr_d  = {head[ENT_W-1 -: 30], 2'b00};
         mem_be_d    = head[35:32];
         mem_wdata_d = head[31:0];
      end
   end

   // Queue bookkeeping and misalignment reporting
   always_comb begin
      queue_d  = queue_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq) begin
         queue_d[wr_ptr_q] = {ea[31:2], st_be, st_data};
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (enq && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !enq) begin
         count_d = count_q - CNT_W'(1);
      end
      misalign_err_d  = accept & st_misal;
      misalign_addr_d = (accept & st_misal) ? ea : misalign_addr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         count_q         <= '0;
         rd_ptr_q        <= '0;
         wr_ptr_q        <= '0;
         mem_req_q       <= 1'b0;
         mem_addr_q      <= 32'h0;
         mem_wdata_q     <= 32'h0;
         mem_be_q        <= 4'b0000;
         misalign_err_q  <= 1'b0;
         misalign_addr_q <= 32'h0;
      end else begin
         state_q         <= state_d;
         count_q         <= count_d;
         rd_ptr_q        <= rd_ptr_d;
         wr_ptr_q        <= wr_ptr_d;
         mem_req_q       <= mem_req_d;
         mem_addr_q      <= mem_addr_d;
         mem_wdata_q     <= mem_wdata_d;
         mem_be_q        <= mem_be_d;
         misalign_err_q  <= misalign_err_d;
         misalign_addr_q <= misalign_addr_d;
      end
   end

   // Queue storage needs no reset: the pointers and count define which entries are live
   always_ff @(posedge clk) begin
      queue_q <= queue_d;
   end

   assign mem_req       = mem_req_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_be        = mem_be_q;
   assign misalign_err  = misalign_err_q;
   assign misalign_addr = misalign_addr_q;
   assign busy          = (count_q != '0) | mem_req_q;

endmodule

// File: doc/store_issue_ctrl.md
# store_issue_ctrl

Store issue controller between the decode stage and the data-memory write port. It accepts decoded store operations (`store_control`, `rs1` value, `rs2` value, 12-bit `imm`) and computes the effective address. It rejects misaligned stores, buffers legal stores in an in-order queue, and sequences them onto a single-outstanding, req/ack memory write port with byte enables and lane-replicated data.

## Interface
- `DEPTH`, 4: store queue entries, power of two, at least 2. Total capacity is `DEPTH` plus 1 in-flight register.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `st_valid`  in  1  store operation offered.
- `st_ready`  out  1  store accepted this cycle when `st_valid && st_ready`.
- `store_control`  in  3  store type, using the `` `SB ``/`` `SH ``/`` `SW ``/`` `STR_NOP `` encodings from processor_defines.sv.
- `rs1_val`  in  32  base register value.
- `rs2_val`  in  32  store data register value.
- `imm`  in  12  signed store offset.
- `mem_req`  out  1  write request to data memory.
- `mem_addr`  out  32  word-aligned write address, with bits [1:0] = 0.
- `mem_wdata`  out  32  write data, lane-replicated.
- `mem_be`  out  4  byte enables; bit i enables byte lane i.
- `mem_ack`  in  1  memory accepted the write; sampled only while `mem_req` = 1.
- `misalign_err`  out  1  one-cycle pulse for a rejected misaligned store.
- `misalign_addr`  out  32  effective address of the last rejected store.
- `busy`  out  1  queue non-empty or `mem_req` high.

## Operation
- Effective address: `ea = rs1_val + sign-extended imm`, computed modulo 2^32 (wraps).
- `st_ready`:
  - equals `count < DEPTH`, combinational from the registered count;
  - forced to 0 while `reset` = 1;
  - has no bypass: a full queue stays not-ready even in a cycle where it pops.
- Handling of an accepted store, by type:
  - `` `SW ``: requires `ea[1:0] = 0`. Then `be = 1111`, `data = rs2_val`.
  - `` `SH ``: requires `ea[0] = 0`. Then `be = 1100` if `ea[1]`, else `0011`; `data = {2{rs2_val[15:0]}}`.
  - `` `SB ``: `be = 1 << ea[1:0]`, `data = {4{rs2_val[7:0]}}`.
  - `` `STR_NOP `` or any other code: accepted and discarded, with no queue entry and no error.
  - Misaligned `SH`/`SW`: accepted but not enqueued. `misalign_err` = 1 in the next cycle, and `misalign_addr` latches `ea`.
- Queue entry holds `{ea[31:2], be, data}`. The queue is strictly FIFO, so memory sees stores in program order.
- FSM with two states, IDLE and REQ:
  - IDLE: if the queue is non-empty, pop the head into the output registers. `mem_req` goes to 1 next cycle and the FSM moves to REQ.
  - REQ: hold `mem_req`, `mem_addr`, `mem_wdata` and `mem_be` stable until `mem_ack` = 1.
    - On ack with the queue non-empty: pop the next entry into the output registers and stay in REQ, so `mem_req` remains 1 with the new payload.
    - On ack with the queue empty: `mem_req` goes to 0 and the FSM moves to IDLE.
- Simultaneous enqueue and pop: the count is unchanged and both pointers advance.
- `mem_ack` while `mem_req` = 0 is ignored.

## Timing
- Reset values:
  - state IDLE; count, read pointer and write pointer = 0;
  - `mem_req` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_be` = 0;
  - `misalign_err` = 0, `misalign_addr` = 0;
  - `busy` = 0; `st_ready` = 0 while in reset, 1 after.
- Latency, empty queue and IDLE: a store accepted in cycle 0 drives `mem_req` = 1 in cycle 2.
- Throughput: with `mem_ack` = 1 every cycle and the queue kept fed, one store retires per cycle.
- `misalign_err` is registered: it is high exactly one cycle, in the cycle after acceptance.
- Reset mid-request:
  - `mem_req` drops in the cycle after `reset` is sampled;
  - the in-flight store and all queued stores are discarded;
  - the memory side tolerates an abandoned request.
- `busy` is combinational: `(count != 0) | mem_req`.

## Test plan
- **Aligned SW:** `SW`, `rs1_val` = 0x00001000, `imm` = 0x004, `rs2_val` = 0xDEADBEEF, `mem_ack` tied 1 -> `mem_req` high in cycle 2 only, with `mem_addr` = 0x00001004, `mem_be` = 1111, `mem_wdata` = 0xDEADBEEF; `busy` = 0 by cycle 3.
- **SB with negative offset:** `SB`, `rs1_val` = 0x00002000, `imm` = 0xFFF, `rs2_val` = 0x123456AB -> `mem_addr` = 0x00001FFC, `mem_be` = 1000, `mem_wdata` = 0xABABABAB.
- **SH misaligned then aligned:**
  - `SH` with `ea` = 0x00003001 -> `misalign_err` pulses for 1 cycle, `misalign_addr` = 0x00003001, no `mem_req`.
  - Then `SH` with `ea` = 0x00003002, `rs2_val` = 0x0000CAFE -> `mem_be` = 1100, `mem_wdata` = 0xCAFECAFE.
- **Backpressure:** `DEPTH` = 4, `mem_ack` held 0, six consecutive valid `SW` stores.
  - Exactly 5 are accepted; `st_ready` is low from the 6th offer on.
  - Then `mem_ack` = 1 every cycle -> `mem_req` stays continuously high for 5 cycles, addresses appear in issue order, and `st_ready` returns high.
- **Reset mid-request:** with `mem_req` = 1 and 2 entries queued, pulse `reset` for 1 cycle.
  - Next cycle: `mem_req` = 0, `busy` = 0, `st_ready` = 1.
  - A following `SW` issues normally.
- **Wrap and NOP:**
  - `rs1_val` = 0xFFFFFFFC, `imm` = 0x008, `SW` -> `mem_addr` = 0x00000004.
  - `` `STR_NOP `` accepted -> no `mem_req`, no `misalign_err`, `busy` stays 0.
